mmio_io_bank: RTL and testbench

Parametrised memory-mapped I/O peripheral that replaces the single-register LED driver on the core's IO region (`addr[22]` = 1). It provides NUM_CH byte-maskable output channel registers, a free-running 32-bit cycle counter, and a 32-bit down-counting timer with auto-reload and an interrupt line. All registers are readable, so firmware can read back outputs and poll time. It sits beside the data memory on the core's single-cycle load/store path.

---
 rtl/mmio_io_bank.sv | 137 +++++++++++++
 tb/tb_mmio_io_bank.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_io_bank.sv
// Memory-mapped IO bank: byte-maskable output channels, a free-running cycle
// counter and a down-counting timer with auto-reload and a level interrupt.
module mmio_io_bank #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned CH_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sel,
    input  logic                         wr_en,
    input  logic [31:0]                  addr,
    input  logic [31:0]                  wdata,
    input  logic [3:0]                   wmask,
    output logic [31:0]                  rdata,
    output logic [NUM_CH*CH_WIDTH-1:0]   ch_out,
    output logic                         irq
);

    localparam logic [3:0] IDX_CYCLE  = 4'd8;
    localparam logic [3:0] IDX_LOAD   = 4'd9;
    localparam logic [3:0] IDX_CTRL   = 4'd10;
    localparam logic [3:0] IDX_COUNT  = 4'd11;
    localparam logic [3:0] IDX_STATUS = 4'd12;

    logic [CH_WIDTH-1:0] ch_q [NUM_CH];
    logic [31:0]         cycle_q;
    logic [31:0]         load_q;
    logic [31:0]         count_q;
    logic                en_q;
    logic                auto_q;
    logic                ie_q;
    logic                exp_q;

    logic [3:0] idx;
    logic       we;
    logic       ctrl_wr;
    logic       stat_clr;
    logic       en_rise;
    logic       expire;
    logic       unused_addr;

    assign idx         = addr[5:2];
    assign we          = sel & wr_en;
    assign ctrl_wr     = we && (idx == IDX_CTRL) && wmask[0];
    assign stat_clr    = we && (idx == IDX_STATUS) && wmask[0] && wdata[0];
    assign en_rise     = ctrl_wr && wdata[0] && !en_q;
    assign expire      = en_q && (count_q == 32'd1);
    assign unused_addr = ^{addr[31:6], addr[1:0]};

    // Replace only the byte lanes enabled by m.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  m);
        logic [31:0] r;
        r = old_v;
        for (int k = 0; k < 4; k++) begin
            if (m[k]) r[8*k +: 8] = new_v[8*k +: 8];
        end
        return r;
    endfunction

    // Channel registers; bits at or above CH_WIDTH are never stored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) ch_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (we && (idx == 4'(i)))
                    ch_q[i] <= CH_WIDTH'(lane_merge(32'(ch_q[i]), wdata, wmask));
            end
        end
    end

    // Cycle counter, LOAD/CTRL/STATUS and the timer countdown.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_q <= '0;
            load_q  <= '0;
            count_q <= '0;
            en_q    <= 1'b0;
            auto_q  <= 1'b0;
            ie_q    <= 1'b0;
            exp_q   <= 1'b0;
        end else begin
            cycle_q <= cycle_q + 32'd1;

            if (we && (idx == IDX_LOAD))
                load_q <= lane_merge(load_q, wdata, wmask);

            if (en_rise)
                count_q <= load_q;
            else if (en_q && (count_q != 32'd0))
                count_q <= count_q - 32'd1;
            else if (en_q && auto_q)
                count_q <= load_q;

            if (ctrl_wr) begin
                en_q   <= wdata[0];
                auto_q <= wdata[1];
                ie_q   <= wdata[2];
            end else if (expire && !auto_q) begin
                en_q <= 1'b0;
            end

            // An expiry on the same edge as a clear keeps EXP set.
            if (expire)
                exp_q <= 1'b1;
            else if (stat_clr)
                exp_q <= 1'b0;
        end
    end

    always_comb begin
        ch_out = '0;
        for (int i = 0; i < NUM_CH; i++) ch_out[i*CH_WIDTH +: CH_WIDTH] = ch_q[i];
    end

    assign irq = exp_q & ie_q;

    // Read mux, independent of sel and wr_en.
    always_comb begin
        rdata = '0;
        case (idx)
            IDX_CYCLE:  rdata = cycle_q;
            IDX_LOAD:   rdata = load_q;
            IDX_CTRL:   rdata = {29'd0, ie_q, auto_q, en_q};
            IDX_COUNT:  rdata = count_q;
            IDX_STATUS: rdata = {31'd0, exp_q};
            default: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (idx == 4'(i)) rdata = 32'(ch_q[i]);
                end
            end
        endcase
    end

endmodule

// File: tb/tb_mmio_io_bank.sv
// Directed bench for mmio_io_bank with a per-cycle reference model and
// hand-computed literal checks.
module tb_mmio_io_bank;

    localparam int unsigned NUM_CH   = 4;
    localparam int unsigned CH_WIDTH = 8;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       sel;
    logic                       wr_en;
    logic [31:0]                addr;
    logic [31:0]                wdata;
    logic [3:0]                 wmask;
    logic [31:0]                rdata;
    logic [NUM_CH*CH_WIDTH-1:0] ch_out;
    logic                       irq;

    mmio_io_bank #(.NUM_CH(NUM_CH), .CH_WIDTH(CH_WIDTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .sel    (sel),
        .wr_en  (wr_en),
        .addr   (addr),
        .wdata  (wdata),
        .wmask  (wmask),
        .rdata  (rdata),
        .ch_out (ch_out),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    logic [31:0] m_ch [NUM_CH];
    logic [31:0] m_cycle, m_load, m_count;
    bit          m_en, m_auto, m_ie, m_exp;
    bit          poke = 1'b0;
    logic [31:0] poke_val = '0;

    function automatic logic [31:0] keep_mask();
        return 32'((64'd1 << CH_WIDTH) - 64'd1);
    endfunction

    function automatic logic [31:0] bytes_in(input logic [31:0] o, input logic [31:0] n, input logic [3:0] m);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input int idx);
        if (idx < int'(NUM_CH)) return m_ch[idx];
        case (idx)
            8:  return m_cycle;
            9:  return m_load;
            10: return {29'd0, m_ie, m_auto, m_en};
            11: return m_count;
            12: return {31'd0, m_exp};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] model_chout();
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < int'(NUM_CH); i++) r[i*CH_WIDTH +: CH_WIDTH] = m_ch[i][CH_WIDTH-1:0];
        return r;
    endfunction

    task automatic model_step();
        logic [31:0] n_count;
        bit n_en, n_exp, fired;
        int idx;
        n_count = m_count;
        n_en    = m_en;
        n_exp   = m_exp;
        fired   = 1'b0;
        idx     = int'(addr[5:2]);
        if (m_en) begin
            if (m_count > 32'd1) n_count = m_count - 32'd1;
            else if (m_count == 32'd1) begin
                n_count = 32'd0;
                n_exp   = 1'b1;
                fired   = 1'b1;
                if (!m_auto) n_en = 1'b0;
            end else if (m_auto) n_count = m_load;
        end
        if (sel && wr_en) begin
            if (idx < int'(NUM_CH))
                m_ch[idx] = bytes_in(m_ch[idx], wdata, wmask) & keep_mask();
            else if (idx == 9)
                m_load = bytes_in(m_load, wdata, wmask);
            else if (idx == 10 && wmask[0]) begin
                if (wdata[0] && !m_en) n_count = m_load;
                n_en   = wdata[0];
                m_auto = wdata[1];
                m_ie   = wdata[2];
            end else if (idx == 12 && wmask[0] && wdata[0] && !fired)
                n_exp = 1'b0;
        end
        m_count = n_count;
        m_en    = n_en;
        m_exp   = n_exp;
        m_cycle = m_cycle + 32'd1;
    endtask

    always @(posedge clk or posedge reset or posedge poke) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_CH); i++) m_ch[i] = '0;
            m_cycle = '0; m_load = '0; m_count = '0;
            m_en = 1'b0; m_auto = 1'b0; m_ie = 1'b0; m_exp = 1'b0;
        end else if (poke) begin
            m_cycle = poke_val;
        end else begin
            model_step();
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("cyc_ch_out", 32'(ch_out), model_chout());
        chk("cyc_irq", 32'(irq), 32'(m_exp & m_ie));
        chk("cyc_rdata", rdata, model_read(int'(addr[5:2])));
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int idx, input logic [31:0] d, input logic [3:0] m, input bit s);
        sel   = s;
        wr_en = 1'b1;
        addr  = 32'h0040_0000 | 32'(idx << 2);
        wdata = d;
        wmask = m;
        tick();
        sel   = 1'b0;
        wr_en = 1'b0;
        wmask = 4'd0;
    endtask

    task automatic rd_chk(input string name, input int idx, input logic [31:0] exp);
        addr = 32'(idx << 2);
        #1;
        chk(name, rdata, exp);
    endtask

    initial begin
        reset = 1'b1; sel = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0; wmask = '0;
        repeat (3) tick();
        chk("rst_ch_out", 32'(ch_out), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        rd_chk("rst_cycle", 8, 32'd0);
        rd_chk("rst_count", 11, 32'd0);
        reset = 1'b0;
        repeat (5) tick();
        rd_chk("cycle_after_5", 8, 32'd5);

        // Masked channel writes and the unmapped hole.
        wr(1, 32'hAABBCCDD, 4'b0001, 1'b1);
        chk("ch1_out_byte", 32'(ch_out[15:8]), 32'h0000_00DD);
        rd_chk("ch1_read", 1, 32'h0000_00DD);
        wr(1, 32'h11223344, 4'b0010, 1'b1);
        rd_chk("ch1_hi_lane_dropped", 1, 32'h0000_00DD);
        wr(0, 32'h0000_005A, 4'b1111, 1'b1);
        wr(6, 32'hFFFFFFFF, 4'b1111, 1'b1);
        chk("unmapped_no_out", 32'(ch_out), 32'h0000_DD5A);
        rd_chk("unmapped_read", 6, 32'd0);

        // One-shot timer.
        wr(9, 32'd3, 4'b1111, 1'b1);
        wr(10, 32'd5, 4'b0001, 1'b1);
        rd_chk("os_count3", 11, 32'd3);
        tick(); rd_chk("os_count2", 11, 32'd2);
        tick(); rd_chk("os_count1", 11, 32'd1);
        chk("os_irq_pre", 32'(irq), 32'd0);
        tick(); rd_chk("os_count0", 11, 32'd0);
        rd_chk("os_exp", 12, 32'd1);
        chk("os_irq", 32'(irq), 32'd1);
        rd_chk("os_ctrl_en_clr", 10, 32'd4);
        tick(); rd_chk("os_count_hold", 11, 32'd0);
        wr(12, 32'd1, 4'b0001, 1'b1);
        chk("os_irq_cleared", 32'(irq), 32'd0);
        rd_chk("os_exp_cleared", 12, 32'd0);

        // Auto-reload, period LOAD+1, and set-beats-clear.
        wr(9, 32'd2, 4'b1111, 1'b1);
        wr(10, 32'd7, 4'b0001, 1'b1);
        rd_chk("ar_count2", 11, 32'd2);
        tick(); rd_chk("ar_count1", 11, 32'd1);
        tick(); rd_chk("ar_exp1", 12, 32'd1);
        wr(12, 32'd1, 4'b0001, 1'b1);
        rd_chk("ar_reload", 11, 32'd2);
        rd_chk("ar_exp_clr", 12, 32'd0);
        tick();
        wr(12, 32'd1, 4'b0001, 1'b1);
        rd_chk("ar_set_wins", 12, 32'd1);
        chk("ar_irq", 32'(irq), 32'd1);
        wr(10, 32'd0, 4'b0001, 1'b1);
        wr(12, 32'd1, 4'b0001, 1'b1);

        // CYCLE wrap and write-ignore.
        force dut.cycle_q = 32'hFFFF_FFFE;
        poke_val = 32'hFFFF_FFFE;
        poke = 1'b1;
        #1;
        poke = 1'b0;
        release dut.cycle_q;
        rd_chk("wrap_fe", 8, 32'hFFFF_FFFE);
        tick(); rd_chk("wrap_ff", 8, 32'hFFFF_FFFF);
        wr(8, 32'h1234_5678, 4'b1111, 1'b1);
        rd_chk("wrap_zero", 8, 32'd0);
        tick(); rd_chk("cycle_wr_ignored", 8, 32'd1);

        // Write gating by sel.
        wr(0, 32'h0000_00FF, 4'b1111, 1'b0);
        rd_chk("gated_ch0", 0, 32'h0000_005A);

        // Asynchronous reset mid-countdown.
        wr(9, 32'd2, 4'b1111, 1'b1);
        wr(10, 32'd7, 4'b0001, 1'b1);
        tick(); tick(); tick();
        addr = 32'd11 << 2;
        #1;
        chk("pre_rst_count", rdata, 32'd2);
        chk("pre_rst_irq", 32'(irq), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_count", rdata, 32'd0);
        chk("async_irq", 32'(irq), 32'd0);
        chk("async_ch_out", 32'(ch_out), 32'd0);
        rd_chk("async_ctrl", 10, 32'd0);
        tick();
        reset = 1'b0;
        tick(); tick();
        rd_chk("post_rst_cycle", 8, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
